// File: rtl/lc3b_types.sv
// Shared LC-3b types: address word, cache line, and arbiter owner encoding.
// Pure declarations; no logic, no latency, no flow control.
// Line width here matches the arbiter's default LINE_W.
package lc3b_types;
    localparam int LC3B_LINE_W = 128;

    typedef logic [15:0]             lc3b_word;
    typedef logic [LC3B_LINE_W-1:0]  lc3b_line;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_control.sv
// Arbitration FSM: alternates I/D ownership of the shared memory port on ties.
// Latency: grant decided combinationally in IDLE, BUSY from the next edge.
// Backpressure: owner holds the port until pmem_resp; others keep requesting.
module mem_arbiter_control
    import lc3b_types::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic pmem_resp,
    output logic busy,
    output logic owner,
    output logic grant,
    output logic grant_owner
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_grant;

    assign busy  = (state == I_BUSY) || (state == D_BUSY);
    assign owner = (state == D_BUSY) ? GRANT_D : GRANT_I;
    assign grant = (state == IDLE) && (i_req || d_req);
    // D wins unless I is also waiting and D was served last.
    assign grant_owner = (d_req && (!i_req || last_grant == GRANT_I)) ? GRANT_D : GRANT_I;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:           if (grant) state_nxt = (grant_owner == GRANT_D) ? D_BUSY : I_BUSY;
            I_BUSY, D_BUSY: if (pmem_resp) state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
        end else begin
            state <= state_nxt;
            if (busy && pmem_resp)
                last_grant <= owner;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single line-wide memory.
// Latency: command one cycle after request; resp same cycle as pmem_resp.
// Backpressure: requesters hold until their resp; memory stalls via pmem_resp.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [15:0]       i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [15:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [15:0]       pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    logic busy;
    logic owner;
    logic grant;
    logic grant_owner;
    logic done;

    lc3b_word          req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              req_read;
    logic              req_write;

    mem_arbiter_control u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_read),
        .d_req       (d_read | d_write),
        .pmem_resp   (pmem_resp),
        .busy        (busy),
        .owner       (owner),
        .grant       (grant),
        .grant_owner (grant_owner)
    );

    // Memory sees only the captured request, so requesters may change inputs mid-flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_read  <= 1'b0;
            req_write <= 1'b0;
        end else if (grant) begin
            if (grant_owner == GRANT_D) begin
                req_addr  <= d_addr;
                req_read  <= !d_write;
                req_write <= d_write;
                if (d_write)
                    req_wdata <= d_wdata;
            end else begin
                req_addr  <= i_addr;
                req_read  <= 1'b1;
                req_write <= 1'b0;
            end
        end else if (done) begin
            req_read  <= 1'b0;
            req_write <= 1'b0;
        end
    end

    assign done       = busy && pmem_resp;
    assign i_resp     = done && (owner == GRANT_I);
    assign d_resp     = done && (owner == GRANT_D);
    assign i_rdata    = pmem_rdata;
    assign d_rdata    = pmem_rdata;
    assign pmem_read  = req_read;
    assign pmem_write = req_write;
    assign pmem_addr  = req_addr;
    assign pmem_wdata = req_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed I/D traffic, a reactive memory model,
// and a monitor that checks every resp and every busy cycle against expectations.
module tb_mem_arbiter;
    import lc3b_types::*;

    localparam int LW = LC3B_LINE_W;

    logic          clk;
    logic          reset;
    logic          i_read;
    logic [15:0]   i_addr;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [15:0]   d_addr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [15:0]   pmem_addr;
    logic [LW-1:0] pmem_wdata;
    lc3b_line      pmem_rdata;
    logic          pmem_resp;

    mem_arbiter #(.LINE_W(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            is_d;
        bit            is_wr;
        logic [15:0]   addr;
        logic [LW-1:0] wdata;
    } txn_t;

    typedef enum int {S_PREAD, S_PWRITE, S_IRESP, S_DRESP, S_PADDR, S_PWDATA, S_QLEFT} sig_e;

    typedef struct {
        string         name;
        sig_e          sel;
        logic [LW-1:0] exp;
    } dchk_t;

    txn_t  exp_q[$];
    dchk_t dchk_q[$];

    int total = 0;
    int bad   = 0;

    int resp_delay = 2;
    bit resp_en    = 1'b1;
    int spur_cnt   = 0;
    int spur_seen  = 0;

    // Memory contents: distinct per address, all-A5 at 0x1230.
    function automatic logic [LW-1:0] mem_data(input logic [15:0] a);
        return {16{8'hA5}} ^ {8{a ^ 16'h1230}};
    endfunction

    function automatic logic [LW-1:0] sample(input sig_e s);
        case (s)
            S_PREAD:  return {{(LW-1){1'b0}}, pmem_read};
            S_PWRITE: return {{(LW-1){1'b0}}, pmem_write};
            S_IRESP:  return {{(LW-1){1'b0}}, i_resp};
            S_DRESP:  return {{(LW-1){1'b0}}, d_resp};
            S_PADDR:  return LW'(pmem_addr);
            S_PWDATA: return pmem_wdata;
            default:  return LW'(exp_q.size());
        endcase
    endfunction

    task automatic push_chk(input string n, input sig_e s, input logic [LW-1:0] e);
        dchk_t d;
        d.name = n;
        d.sel  = s;
        d.exp  = e;
        dchk_q.push_back(d);
    endtask

    task automatic push_txn(input bit is_d, input bit is_wr, input logic [15:0] a, input logic [LW-1:0] wd);
        txn_t t;
        t.is_d  = is_d;
        t.is_wr = is_wr;
        t.addr  = a;
        t.wdata = wd;
        exp_q.push_back(t);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input bit is_d);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(is_d ? d_resp : i_resp) && cyc < 60);
        if (!(is_d ? d_resp : i_resp))
            push_chk(is_d ? "d_resp_timeout" : "i_resp_timeout", is_d ? S_DRESP : S_IRESP, 1);
    endtask

    task automatic i_run(input int n, input logic [15:0] base);
        i_read = 1'b1;
        for (int k = 0; k < n; k++) begin
            i_addr = base + 16'(k * 16);
            wait_resp(1'b0);
            @(posedge clk);
            #1;
        end
        i_read = 1'b0;
    endtask

    task automatic d_run(input int n, input logic [15:0] base, input bit rd, input bit wr,
                         input logic [LW-1:0] wd, input bit scramble);
        d_read  = rd;
        d_write = wr;
        d_wdata = wd;
        for (int k = 0; k < n; k++) begin
            d_addr = base + 16'(k * 16);
            if (scramble) begin
                @(posedge clk);
                #1;
                d_addr  = '0;
                d_wdata = '0;
            end
            wait_resp(1'b1);
            @(posedge clk);
            #1;
        end
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    // Memory model: answers each command after resp_delay cycles; can also fire a stray resp.
    initial begin
        logic [15:0] a;
        pmem_resp  = 1'b0;
        pmem_rdata = '1;
        forever begin
            @(negedge clk);
            if (resp_en && !reset && (pmem_read || pmem_write)) begin
                a = pmem_addr;
                repeat (resp_delay) @(posedge clk);
                #1;
                pmem_resp  = 1'b1;
                pmem_rdata = mem_data(a);
                @(posedge clk);
                #1;
                pmem_resp  = 1'b0;
                pmem_rdata = '1;
            end else if (spur_cnt != spur_seen) begin
                spur_seen++;
                @(posedge clk);
                #1;
                pmem_resp  = 1'b1;
                pmem_rdata = {16{8'hEE}};
                @(posedge clk);
                #1;
                pmem_resp  = 1'b0;
                pmem_rdata = '1;
            end
        end
    end

    // Monitor: direct checks first, then resp / busy-cycle checks against the scoreboard.
    initial begin
        dchk_t         d;
        txn_t          t;
        logic [LW-1:0] act;
        logic [LW-1:0] rd;
        bit            ok;
        forever begin
            @(negedge clk);
            while (dchk_q.size() > 0) begin
                d   = dchk_q.pop_front();
                act = sample(d.sel);
                total++;
                if (act !== d.exp) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", d.name, act, d.exp);
                end
            end
            if (i_resp || d_resp) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b want none", i_resp, d_resp);
                end else begin
                    t  = exp_q.pop_front();
                    rd = t.is_d ? d_rdata : i_rdata;
                    ok = !(i_resp && d_resp) && (d_resp == t.is_d) && (pmem_addr == t.addr) &&
                         (pmem_write == t.is_wr) && (pmem_read == !t.is_wr) &&
                         (t.is_wr ? (pmem_wdata == t.wdata) : (rd == mem_data(t.addr)));
                    if (!ok) begin
                        bad++;
                        $display("FAIL resp: got i=%0b d=%0b addr=%h rd=%0b wr=%0b rdata=%h want d=%0b addr=%h wr=%0b rdata=%h",
                                 i_resp, d_resp, pmem_addr, pmem_read, pmem_write, rd,
                                 t.is_d, t.addr, t.is_wr, t.is_wr ? t.wdata : mem_data(t.addr));
                    end
                end
            end else if ((pmem_read || pmem_write) && exp_q.size() > 0) begin
                t  = exp_q[0];
                ok = (pmem_addr == t.addr) && (pmem_write == t.is_wr) && (pmem_read == !t.is_wr) &&
                     (!t.is_wr || pmem_wdata == t.wdata);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL busy_cmd: got addr=%h rd=%0b wr=%0b wdata=%h want addr=%h wr=%0b wdata=%h",
                             pmem_addr, pmem_read, pmem_write, pmem_wdata, t.addr, t.is_wr, t.wdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        i_read  = 1'b0;
        i_addr  = '0;
        d_read  = 1'b0;
        d_write = 1'b0;
        d_addr  = '0;
        d_wdata = '0;

        idle(2);
        push_chk("rst_pread",  S_PREAD,  0);
        push_chk("rst_pwrite", S_PWRITE, 0);
        push_chk("rst_iresp",  S_IRESP,  0);
        push_chk("rst_dresp",  S_DRESP,  0);
        push_chk("rst_paddr",  S_PADDR,  0);
        push_chk("rst_pwdata", S_PWDATA, 0);
        idle(1);
        reset = 1'b0;
        idle(2);

        // Single I fill: command one cycle after request, resp with A5 data.
        resp_delay = 3;
        push_txn(1'b0, 1'b0, 16'h1230, '0);
        push_chk("i_cycle0_pread", S_PREAD, 0);
        fork
            i_run(1, 16'h1230);
            begin
                idle(1);
                push_chk("i_cycle1_pread", S_PREAD, 1);
                push_chk("i_cycle1_paddr", S_PADDR, LW'(16'h1230));
                push_chk("i_cycle1_dresp", S_DRESP, 0);
            end
        join
        idle(2);

        // Simultaneous first requests: D then I.
        resp_delay = 2;
        push_txn(1'b1, 1'b0, 16'h0100, '0);
        push_txn(1'b0, 1'b0, 16'h0200, '0);
        fork
            i_run(1, 16'h0200);
            d_run(1, 16'h0100, 1'b1, 1'b0, '0, 1'b0);
        join
        idle(2);

        // Continuous re-requests alternate D,I,D,I,D,I (last grant was I).
        for (int k = 0; k < 3; k++) begin
            push_txn(1'b1, 1'b0, 16'h3000 + 16'(k * 16), '0);
            push_txn(1'b0, 1'b0, 16'h5000 + 16'(k * 16), '0);
        end
        fork
            i_run(3, 16'h5000);
            d_run(3, 16'h3000, 1'b1, 1'b0, '0, 1'b0);
        join
        idle(2);

        // Writeback with inputs scrambled after the grant.
        resp_delay = 3;
        push_txn(1'b1, 1'b1, 16'h4000, {16{8'h55}});
        d_run(1, 16'h4000, 1'b0, 1'b1, {16{8'h55}}, 1'b1);
        idle(2);

        // Reset mid D_BUSY, then a late pmem_resp.
        resp_en = 1'b0;
        d_read  = 1'b1;
        d_addr  = 16'h2222;
        idle(1);
        push_chk("midrst_busy_pread", S_PREAD, 1);
        idle(1);
        reset  = 1'b1;
        d_read = 1'b0;
        push_chk("midrst_pread",  S_PREAD,  0);
        push_chk("midrst_pwrite", S_PWRITE, 0);
        push_chk("midrst_dresp",  S_DRESP,  0);
        push_chk("midrst_iresp",  S_IRESP,  0);
        push_chk("midrst_paddr",  S_PADDR,  0);
        idle(2);
        reset = 1'b0;
        spur_cnt++;
        idle(4);
        push_chk("postrst_pread", S_PREAD, 0);
        resp_en    = 1'b1;
        resp_delay = 2;
        idle(1);

        // After reset D must win the tie again.
        push_txn(1'b1, 1'b0, 16'h6000, '0);
        push_txn(1'b0, 1'b0, 16'h7000, '0);
        fork
            i_run(1, 16'h7000);
            d_run(1, 16'h6000, 1'b1, 1'b0, '0, 1'b0);
        join
        idle(2);

        // Stray resp in IDLE, then read+write together is a write.
        spur_cnt++;
        idle(4);
        push_txn(1'b1, 1'b1, 16'h8000, {16{8'h0F}});
        fork
            d_run(1, 16'h8000, 1'b1, 1'b1, {16{8'h0F}}, 1'b0);
            begin
                idle(1);
                push_chk("rw_pwrite", S_PWRITE, 1);
                push_chk("rw_pread",  S_PREAD,  0);
            end
        join
        idle(3);

        push_chk("scoreboard_empty", S_QLEFT, 0);
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
